// File: rtl/instruction_loader.sv
// Packs UART bytes MSB-first into instruction words and writes them
// sequentially into instruction memory until a halt word or a full memory.
module instruction_loader #(
    parameter int          UART_BUS_SIZE    = 8,
    parameter int          INSTRUCTION_SIZE = 32,
    parameter int          MEM_ADDR_SIZE    = 10,
    parameter logic [INSTRUCTION_SIZE-1:0] HALT_INSTRUCTION = 32'hFFFFFFFF
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_rx_done,
    input  logic [UART_BUS_SIZE-1:0]    i_rx_data,
    output logic                        o_mem_wr,
    output logic [MEM_ADDR_SIZE-1:0]    o_mem_addr,
    output logic [INSTRUCTION_SIZE-1:0] o_mem_data,
    output logic                        o_busy,
    output logic                        o_end,
    output logic                        o_full
);

    localparam int BPW = INSTRUCTION_SIZE / UART_BUS_SIZE;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int SW  = INSTRUCTION_SIZE - UART_BUS_SIZE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [INSTRUCTION_SIZE-1:0] shift_q, shift_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [MEM_ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [INSTRUCTION_SIZE-1:0] data_q, data_d;
    logic                        wr_q, wr_d;
    logic                        end_q, end_d;
    logic                        full_q, full_d;

    logic [INSTRUCTION_SIZE-1:0] word;
    logic                        last_byte;
    logic                        halt;
    logic                        addr_last;

    assign word      = {shift_q[SW-1:0], i_rx_data};
    assign last_byte = (cnt_q == CW'(BPW - 1));
    assign halt      = (data_q == HALT_INSTRUCTION);
    assign addr_last = &addr_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_start) state_d = RECEIVE;
            RECEIVE: if (i_rx_done && last_byte) state_d = WRITE;
            WRITE:   state_d = (halt || addr_last) ? IDLE : RECEIVE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        end_d   = end_q;
        full_d  = full_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    cnt_d  = '0;
                    addr_d = '0;
                    end_d  = 1'b0;
                    full_d = 1'b0;
                end
            end
            RECEIVE: begin
                if (i_rx_done) begin
                    shift_d = word;
                    if (last_byte) begin
                        cnt_d  = '0;
                        data_d = word;
                        wr_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (halt) begin
                    end_d = 1'b1;
                end else if (addr_last) begin
                    end_d  = 1'b1;
                    full_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                    // A byte landing in the write cycle opens the next word
                    if (i_rx_done) begin
                        shift_d = word;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            end_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            end_q   <= end_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        o_busy     = (state_q != IDLE);
        o_mem_wr   = wr_q;
        o_mem_addr = addr_q;
        o_mem_data = data_q;
        o_end      = end_q;
        o_full     = full_q;
    end

endmodule
